// File: rtl/mcore_mem_arbiter_pkg.sv
// Shared types for the mcore memory-port arbiter: requester ID width and arbiter state.
package mcore_defs;

   localparam int MEM_ARB_MAX_REQ = 8;
   localparam int MEM_ARB_ID_W    = $clog2(MEM_ARB_MAX_REQ);

   typedef logic [MEM_ARB_ID_W-1:0] req_id_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mcore_tag_fifo.sv
// Small synchronous FIFO with a registered head; push and pop may occur together,
// including a push into a full FIFO when a pop frees the slot in the same cycle.
module mcore_tag_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
         if (w_do_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
         if (w_do_push && !w_do_pop)
            r_count <= r_count + (PW+1)'(1);
         else if (!w_do_push && w_do_pop)
            r_count <= r_count - (PW+1)'(1);
      end
   end

   // Storage carries no reset; occupancy alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter sharing one mem_if port among NUM_REQ masters; an in-order
// tag FIFO remembers who was granted so each response returns to its owner.
module mcore_mem_arbiter
   import mcore_defs::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                            aclk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              s_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr,
   input  logic [NUM_REQ-1:0]              s_we,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_be,
   output logic [NUM_REQ-1:0]              s_gnt,
   output logic [NUM_REQ-1:0]              s_rsp_valid,
   output logic [DATA_WIDTH-1:0]           s_rsp_rdata,
   output logic                            s_rsp_error,
   output logic                            mem_req,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic                            mem_we,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   output logic [DATA_WIDTH/8-1:0]         mem_be,
   input  logic                            mem_gnt,
   input  logic                            mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]           mem_rsp_rdata,
   input  logic                            mem_rsp_error,
   output logic                            err_unexpected
);

   localparam int BE_W = DATA_WIDTH / 8;

   // First asserted request at or after ptr, wrapping modulo NUM_REQ.
   function automatic req_id_t rr_select(input logic [NUM_REQ-1:0] req, input req_id_t ptr);
      logic [2*NUM_REQ-1:0] rot;
      req_id_t              sel;
      logic                 found;
      int                   idx;
      rot   = {req, req} >> ptr;
      sel   = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && rot[j]) begin
            idx = int'(ptr) + j;
            if (idx >= NUM_REQ)
               idx = idx - NUM_REQ;
            sel   = req_id_t'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   req_id_t    r_lock_id;
   req_id_t    w_lock_nxt;
   req_id_t    r_rr_ptr;
   req_id_t    w_rr_nxt;
   req_id_t    w_winner;
   req_id_t    w_head;
   logic       r_err;
   logic       w_any_req;
   logic       w_grant;
   logic       w_pop;
   logic       w_full_eff;
   logic       w_fifo_full;
   logic       w_fifo_empty;

   assign w_any_req  = |s_req;
   assign w_winner   = (r_state == ARB_LOCKED) ? r_lock_id : rr_select(s_req, r_rr_ptr);
   assign w_pop      = mem_rsp_valid & ~w_fifo_empty;
   // A response popping this cycle frees a slot, so a full FIFO can accept again at once.
   assign w_full_eff = w_fifo_full & ~w_pop;
   assign mem_req    = w_any_req & ~w_full_eff;
   assign w_grant    = mem_req & mem_gnt;
   assign w_rr_nxt   = (w_winner == req_id_t'(NUM_REQ-1)) ? '0 : w_winner + req_id_t'(1);

   assign s_rsp_rdata    = mem_rsp_rdata;
   assign s_rsp_error    = mem_rsp_error;
   assign err_unexpected = r_err;

   always_comb begin
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      mem_be      = '0;
      s_gnt       = '0;
      s_rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_any_req && (w_winner == req_id_t'(i))) begin
            mem_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we    = s_we[i];
            mem_wdata = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            mem_be    = s_be[i*BE_W +: BE_W];
         end
         s_gnt[i]       = w_grant & (w_winner == req_id_t'(i));
         s_rsp_valid[i] = w_pop & (w_head == req_id_t'(i));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock_id;
      case (r_state)
         ARB_IDLE: begin
            if (mem_req && !mem_gnt) begin
               w_state_nxt = ARB_LOCKED;
               w_lock_nxt  = w_winner;
            end
         end
         ARB_LOCKED: begin
            if (w_grant)
               w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         r_state   <= ARB_IDLE;
         r_lock_id <= '0;
         r_rr_ptr  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_nxt;
         if (w_grant)
            r_rr_ptr <= w_rr_nxt;
         if (mem_rsp_valid && w_fifo_empty)
            r_err <= 1'b1;
      end
   end

   mcore_tag_fifo #(
      .WIDTH ($bits(req_id_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (aclk),
      .rst     (rst),
      .i_push  (w_grant),
      .i_din   (w_winner),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Bench for mcore_mem_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of grants, outstanding tags and response routing.
module tb_mcore_mem_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 4;

   logic              aclk = 1'b0;
   logic              rst;
   logic [N-1:0]      s_req;
   logic [N*AW-1:0]   s_addr;
   logic [N-1:0]      s_we;
   logic [N*DW-1:0]   s_wdata;
   logic [N*BW-1:0]   s_be;
   logic [N-1:0]      s_gnt;
   logic [N-1:0]      s_rsp_valid;
   logic [DW-1:0]     s_rsp_rdata;
   logic              s_rsp_error;
   logic              mem_req;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [DW-1:0]     mem_wdata;
   logic [BW-1:0]     mem_be;
   logic              mem_gnt;
   logic              mem_rsp_valid;
   logic [DW-1:0]     mem_rsp_rdata;
   logic              mem_rsp_error;
   logic              err_unexpected;

   // Per-requester stimulus as seen by the masters.
   logic          t_req   [N];
   logic [AW-1:0] t_addr  [N];
   logic          t_we    [N];
   logic [DW-1:0] t_wdata [N];
   logic [BW-1:0] t_be    [N];

   // Reference model: outstanding owners in order, next-priority requester, held requester.
   int q[$];
   int rr;
   int lk;
   bit m_err;
   int last_gnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   mcore_mem_arbiter #(
      .NUM_REQ         (N),
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .aclk           (aclk),
      .rst            (rst),
      .s_req          (s_req),
      .s_addr         (s_addr),
      .s_we           (s_we),
      .s_wdata        (s_wdata),
      .s_be           (s_be),
      .s_gnt          (s_gnt),
      .s_rsp_valid    (s_rsp_valid),
      .s_rsp_rdata    (s_rsp_rdata),
      .s_rsp_error    (s_rsp_error),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_wdata      (mem_wdata),
      .mem_be         (mem_be),
      .mem_gnt        (mem_gnt),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_rdata  (mem_rsp_rdata),
      .mem_rsp_error  (mem_rsp_error),
      .err_unexpected (err_unexpected)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_in();
      for (int i = 0; i < N; i++) begin
         s_req[i]              = t_req[i];
         s_we[i]               = t_we[i];
         s_addr[i*AW +: AW]    = t_addr[i];
         s_wdata[i*DW +: DW]   = t_wdata[i];
         s_be[i*BW +: BW]      = t_be[i];
      end
   endtask

   task automatic settle();
      apply_in();
      #1;
   endtask

   task automatic clear_in();
      for (int i = 0; i < N; i++) begin
         t_req[i]   = 1'b0;
         t_addr[i]  = '0;
         t_we[i]    = 1'b0;
         t_wdata[i] = '0;
         t_be[i]    = '0;
      end
      mem_gnt       = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      mem_rsp_error = 1'b0;
      apply_in();
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      rst = 1'b0;
      q.delete();
      rr       = 0;
      lk       = -1;
      m_err    = 1'b0;
      last_gnt = -1;
   endtask

   // One clock: predict and check every output, then advance the model on the edge.
   task automatic cycle();
      int            win;
      bit            any_r;
      bit            pop;
      bit            mreq;
      bit            gnt;
      logic [N-1:0]  eg;
      logic [N-1:0]  ev;
      logic [AW-1:0] ea;
      logic          ew;
      logic [DW-1:0] ed;
      logic [BW-1:0] eb;
      apply_in();
      #1;
      any_r = 1'b0;
      for (int i = 0; i < N; i++) any_r |= t_req[i];
      win = lk;
      if (win < 0)
         for (int k = 0; k < N; k++)
            if (win < 0 && t_req[(rr + k) % N]) win = (rr + k) % N;
      pop  = mem_rsp_valid && (q.size() > 0);
      mreq = any_r && !((q.size() == MO) && !pop);
      gnt  = mreq && mem_gnt;
      eg = '0;
      ev = '0;
      if (gnt) eg[win] = 1'b1;
      if (pop) ev[q[0]] = 1'b1;
      ea = '0; ew = 1'b0; ed = '0; eb = '0;
      if (any_r) begin
         ea = t_addr[win]; ew = t_we[win]; ed = t_wdata[win]; eb = t_be[win];
      end
      chk("s_gnt", s_gnt, eg);
      chk("s_rsp_valid", s_rsp_valid, ev);
      chk("mem_req", mem_req, mreq);
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", mem_we, ew);
      chk("mem_wdata", mem_wdata, ed);
      chk("mem_be", mem_be, eb);
      chk("s_rsp_rdata", s_rsp_rdata, mem_rsp_rdata);
      chk("s_rsp_error", s_rsp_error, mem_rsp_error);
      chk("err_unexpected", err_unexpected, m_err);
      @(posedge aclk);
      last_gnt = gnt ? win : -1;
      if (mem_rsp_valid && q.size() == 0) m_err = 1'b1;
      if (pop) void'(q.pop_front());
      if (gnt) begin
         q.push_back(win);
         rr = (win + 1) % N;
         lk = -1;
      end else if (mreq && !mem_gnt && lk < 0) begin
         lk = win;
      end
      #1;
   endtask

   initial begin
      logic [N-1:0] e;
      rst = 1'b1;
      do_reset();

      // Reset state
      settle();
      chk("rst_s_gnt", s_gnt, 0);
      chk("rst_rsp_valid", s_rsp_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_err", err_unexpected, 0);
      cycle();

      // Single read from requester 1
      t_req[1] = 1'b1; t_addr[1] = 32'h000a_8f78; mem_gnt = 1'b1;
      settle();
      chk("single_gnt", s_gnt, 4'b0010);
      chk("single_addr", mem_addr, 32'h000a_8f78);
      cycle();
      t_req[1] = 1'b0; mem_gnt = 1'b0;
      cycle();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0240_9f96;
      settle();
      chk("single_rsp_vld", s_rsp_valid, 4'b0010);
      chk("single_rdata", s_rsp_rdata, 32'h0240_9f96);
      cycle();
      mem_rsp_valid = 1'b0;
      // rr_ptr now points at 2: requester 2 beats requester 1
      t_req[1] = 1'b1; t_addr[1] = 32'h100; t_req[2] = 1'b1; t_addr[2] = 32'h200; mem_gnt = 1'b1;
      settle();
      chk("rr_after_single", s_gnt, 4'b0100);
      cycle();
      t_req[2] = 1'b0;
      cycle();
      t_req[1] = 1'b0; mem_gnt = 1'b0; mem_rsp_valid = 1'b1;
      cycle();
      cycle();
      mem_rsp_valid = 1'b0;

      // Fairness: everyone requesting, one-cycle response latency
      do_reset();
      for (int i = 0; i < N; i++) begin
         t_req[i] = 1'b1; t_addr[i] = 32'h4000 + 32'(i * 16); t_we[i] = i[0];
         t_wdata[i] = 32'hA5A5_0000 + 32'(i); t_be[i] = 4'(i + 1);
      end
      mem_gnt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_rsp_valid = (i > 0);
         mem_rsp_rdata = 32'(i * 3);
         settle();
         e = '0; e[i % N] = 1'b1;
         chk("fair_gnt", s_gnt, e);
         if (i > 0) begin
            e = '0; e[(i - 1) % N] = 1'b1;
            chk("fair_rsp", s_rsp_valid, e);
         end
         cycle();
      end
      for (int i = 0; i < N; i++) t_req[i] = 1'b0;
      mem_rsp_valid = 1'b1;
      cycle();
      mem_rsp_valid = 1'b0;

      // Backpressure: request held on requester 0 while mem_gnt is low
      do_reset();
      t_req[0] = 1'b1; t_addr[0] = 32'h1000; t_req[2] = 1'b1; t_addr[2] = 32'h2000;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_addr", mem_addr, 32'h1000);
         chk("bp_no_gnt", s_gnt, 0);
         cycle();
      end
      mem_gnt = 1'b1;
      settle();
      chk("bp_gnt0", s_gnt, 4'b0001);
      cycle();
      t_req[0] = 1'b0;
      settle();
      chk("bp_gnt2", s_gnt, 4'b0100);
      cycle();
      t_req[2] = 1'b0; mem_gnt = 1'b0; mem_rsp_valid = 1'b1;
      cycle();
      cycle();
      mem_rsp_valid = 1'b0;
      // Lock holds requester 2 even when higher-priority requester 0 appears
      do_reset();
      t_req[2] = 1'b1; t_addr[2] = 32'h2222;
      cycle();
      t_req[0] = 1'b1; t_addr[0] = 32'h0000_0111;
      settle();
      chk("lock_addr", mem_addr, 32'h2222);
      cycle();
      mem_gnt = 1'b1;
      cycle();
      t_req[2] = 1'b0;
      cycle();
      t_req[0] = 1'b0; mem_gnt = 1'b0; mem_rsp_valid = 1'b1;
      cycle();
      cycle();
      mem_rsp_valid = 1'b0;

      // FIFO full, then pop re-enables the request in the same cycle
      do_reset();
      for (int i = 0; i < N; i++) begin
         t_req[i] = 1'b1; t_addr[i] = 32'h8000 + 32'(i);
      end
      mem_gnt = 1'b1;
      for (int i = 0; i < MO; i++) cycle();
      settle();
      chk("full_mem_req", mem_req, 0);
      chk("full_no_gnt", s_gnt, 0);
      cycle();
      mem_rsp_valid = 1'b1;
      settle();
      chk("full_pop_req", mem_req, 1);
      chk("full_pop_rsp", s_rsp_valid, 4'b0001);
      chk("full_pop_gnt", s_gnt, 4'b0001);
      cycle();
      for (int i = 0; i < N; i++) t_req[i] = 1'b0;
      cycle();
      cycle();
      // Occupancy 2 (tags 3,0): push and pop together
      t_req[1] = 1'b1;
      settle();
      chk("pp_rsp", s_rsp_valid, 4'b1000);
      chk("pp_gnt", s_gnt, 4'b0010);
      cycle();
      t_req[1] = 1'b0; mem_gnt = 1'b0;
      settle();
      chk("pp_drain0", s_rsp_valid, 4'b0001);
      cycle();
      settle();
      chk("pp_drain1", s_rsp_valid, 4'b0010);
      chk("pp_err_clear", err_unexpected, 0);
      cycle();
      // Stray response with the FIFO empty
      settle();
      chk("stray_rsp", s_rsp_valid, 0);
      cycle();
      mem_rsp_valid = 1'b0;
      settle();
      chk("stray_err", err_unexpected, 1);
      cycle();

      // Reset in the middle of an outstanding transaction
      t_req[3] = 1'b1; t_addr[3] = 32'hdead_0000; mem_gnt = 1'b1;
      cycle();
      do_reset();
      settle();
      chk("mrst_gnt", s_gnt, 0);
      chk("mrst_rsp", s_rsp_valid, 0);
      chk("mrst_req", mem_req, 0);
      chk("mrst_addr", mem_addr, 0);
      chk("mrst_err", err_unexpected, 0);
      cycle();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
      settle();
      chk("late_rsp", s_rsp_valid, 0);
      cycle();
      mem_rsp_valid = 1'b0;
      settle();
      chk("late_err", err_unexpected, 1);
      cycle();

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!t_req[i]) begin
               t_addr[i]  = $urandom;
               t_we[i]    = 1'($urandom_range(0, 1));
               t_wdata[i] = $urandom;
               t_be[i]    = 4'($urandom_range(0, 15));
               t_req[i]   = ($urandom_range(0, 2) == 0);
            end
         end
         mem_gnt       = ($urandom_range(0, 3) != 0);
         mem_rsp_valid = (q.size() > 0) && ($urandom_range(0, 9) < ((c < 300) ? 3 : 7));
         mem_rsp_rdata = $urandom;
         mem_rsp_error = 1'($urandom_range(0, 1));
         cycle();
         if (last_gnt >= 0) t_req[last_gnt] = 1'b0;
      end
      for (int i = 0; i < N; i++) t_req[i] = 1'b0;
      mem_gnt = 1'b0;
      for (int k = 0; k < MO + 2; k++) begin
         mem_rsp_valid = (q.size() > 0);
         cycle();
      end
      mem_rsp_valid = 1'b0;
      settle();
      chk("final_err", err_unexpected, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
